// File: rtl/mprj_ckpt_pkg.sv
// Shared state encoding, result codes and the saturating increment used by the checkpoint monitor.
package mprj_ckpt_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, DONE_PASS, DONE_FAIL} ckpt_state_e;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_ORDER   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/mprj_ckpt_stable_filter.sv
// Stability filter for the marker bus: the output takes a new value only after
// STABLE_N identical consecutive samples, giving a fixed STABLE_N-cycle delay.
module mprj_ckpt_stable_filter
  import mprj_ckpt_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int STABLE_N = 3
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);

  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [RUN_W-1:0]  run_q, run_d;

  always_comb begin
    last_d = din;
    hold_d = hold_q;
    if (din != last_q)       run_d = RUN_W'(1);
    else if (run_q < RUN_MAX) run_d = run_q + RUN_W'(1);
    else                      run_d = run_q;
    if (run_d == RUN_MAX) hold_d = din;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      last_q <= '0;
      hold_q <= '0;
      run_q  <= '0;
    end else begin
      last_q <= last_d;
      hold_q <= hold_d;
      run_q  <= run_d;
    end
  end

  assign dout = hold_q;

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Firmware checkpoint monitor: checks an ordered marker sequence on checkbits and times the gaps.
// Defining CKPT_GLITCH_FILTER_EN puts mprj_ckpt_stable_filter in front of the match logic.
//   state     | meaning
//   IDLE      | out of reset, waiting for the first start
//   ARMED     | sequence in progress, gap counter running
//   DONE_PASS | every marker seen in order
//   DONE_FAIL | order error or timeout, flags held until the next start
module mprj_checkpoint_monitor
  import mprj_ckpt_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_CKPT = 4,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1000000,
  parameter int STABLE_N = 3
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic [DATA_W-1:0]           checkbits,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CKPT)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]           cfg_data,
  input  logic [$clog2(NUM_CKPT):0]   cfg_len,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        err_order,
  output logic                        err_timeout,
  output logic [$clog2(NUM_CKPT):0]   ckpt_idx,
  output logic                        lat_valid,
  output logic [CNT_W-1:0]            lat_cycles
);

  localparam int IDX_W = $clog2(NUM_CKPT);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [63:0] TIMEOUT_64 = 64'(TIMEOUT);

  ckpt_state_e       state_q, state_d;
  logic [LEN_W-1:0]  ckpt_idx_q, ckpt_idx_d;
  logic [LEN_W-1:0]  len_q, len_d, len_start;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d, gap_inc;
  logic [CNT_W-1:0]  lat_cycles_q, lat_cycles_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] exp_q [NUM_CKPT];
  logic [DATA_W-1:0] exp_d [NUM_CKPT];
  logic first_q, first_d;
  logic done_q, done_d, pass_q, pass_d;
  logic err_order_q, err_order_d, err_timeout_q, err_timeout_d;
  logic lat_valid_q, lat_valid_d;
  logic [DATA_W-1:0] mon;
  logic cur_hit, later_hit, new_ev, last_slot, timeout_hit;
  logic [1:0] res;

`ifdef CKPT_GLITCH_FILTER_EN
  mprj_ckpt_stable_filter #(.DATA_W(DATA_W), .STABLE_N(STABLE_N)) u_filter (
    .clock  (clock),
    .resetb (resetb),
    .din    (checkbits),
    .dout   (mon)
  );
`else
  localparam int unused_stable_n = STABLE_N;
  assign mon = checkbits;
`endif

  always_comb begin
    exp_d = exp_q;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (cfg_we && cfg_idx == IDX_W'(j)) exp_d[j] = cfg_data;
    end
  end

  // Codes are compared slot by slot so ckpt_idx == len never indexes past the array.
  always_comb begin
    cur_hit   = 1'b0;
    later_hit = 1'b0;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (mon == exp_q[j]) begin
        if (LEN_W'(j) == ckpt_idx_q) cur_hit = 1'b1;
        if (LEN_W'(j) > ckpt_idx_q && LEN_W'(j) < len_q) later_hit = 1'b1;
      end
    end
  end

  assign gap_inc     = CNT_W'(sat_inc(64'(gap_cnt_q), CNT_W));
  assign timeout_hit = (64'(gap_inc) >= TIMEOUT_64);
  assign new_ev      = (mon != prev_q) || first_q;
  assign last_slot   = ((ckpt_idx_q + LEN_W'(1)) == len_q);
  assign prev_d      = mon;

  always_comb begin
    if (cfg_len == '0)                      len_start = LEN_W'(1);
    else if (cfg_len > LEN_W'(NUM_CKPT))    len_start = LEN_W'(NUM_CKPT);
    else                                    len_start = cfg_len;
  end

  always_comb begin
    state_d       = state_q;
    ckpt_idx_d    = ckpt_idx_q;
    len_d         = len_q;
    gap_cnt_d     = gap_cnt_q;
    first_d       = 1'b0;
    done_d        = done_q;
    pass_d        = pass_q;
    err_order_d   = err_order_q;
    err_timeout_d = err_timeout_q;
    lat_valid_d   = 1'b0;
    lat_cycles_d  = lat_cycles_q;
    res           = RES_NONE;
    if (start) begin
      state_d       = ARMED;
      ckpt_idx_d    = '0;
      len_d         = len_start;
      gap_cnt_d     = '0;
      first_d       = 1'b1;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      err_order_d   = 1'b0;
      err_timeout_d = 1'b0;
    end else if (state_q == ARMED) begin
      // A held value is not a new event, so it can neither re-match nor raise an order error.
      if (cur_hit && new_ev) begin
        lat_valid_d  = 1'b1;
        lat_cycles_d = gap_inc;
        gap_cnt_d    = '0;
        ckpt_idx_d   = ckpt_idx_q + LEN_W'(1);
        if (last_slot) res = RES_PASS;
      end else if (later_hit && new_ev) begin
        res = RES_ORDER;
      end else begin
        gap_cnt_d = gap_inc;
        if (timeout_hit) res = RES_TIMEOUT;
      end
    end
    case (res)
      RES_PASS: begin
        state_d = DONE_PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end
      RES_ORDER: begin
        state_d     = DONE_FAIL;
        done_d      = 1'b1;
        err_order_d = 1'b1;
      end
      RES_TIMEOUT: begin
        state_d       = DONE_FAIL;
        done_d        = 1'b1;
        err_timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      ckpt_idx_q    <= '0;
      len_q         <= '0;
      gap_cnt_q     <= '0;
      prev_q        <= '0;
      first_q       <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_order_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      lat_valid_q   <= 1'b0;
      lat_cycles_q  <= '0;
      for (int j = 0; j < NUM_CKPT; j++) exp_q[j] <= '0;
    end else begin
      state_q       <= state_d;
      ckpt_idx_q    <= ckpt_idx_d;
      len_q         <= len_d;
      gap_cnt_q     <= gap_cnt_d;
      prev_q        <= prev_d;
      first_q       <= first_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_order_q   <= err_order_d;
      err_timeout_q <= err_timeout_d;
      lat_valid_q   <= lat_valid_d;
      lat_cycles_q  <= lat_cycles_d;
      exp_q         <= exp_d;
    end
  end

  assign busy        = (state_q == ARMED);
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_order   = err_order_q;
  assign err_timeout = err_timeout_q;
  assign ckpt_idx    = ckpt_idx_q;
  assign lat_valid   = lat_valid_q;
  assign lat_cycles  = lat_cycles_q;

endmodule
